// File: rtl/servo_pkg.sv
// servo_pkg: register map, CTRL bit index and value helpers shared by the servo controller.
package servo_pkg;

    localparam int unsigned ADDR_CTRL   = 0;
    localparam int unsigned ADDR_STEP   = 1;
    localparam int unsigned ADDR_TARGET = 2;
    localparam int          CTRL_EN     = 0;

    function automatic int unsigned addr_current(input int unsigned num_ch);
        return ADDR_TARGET + num_ch;
    endfunction

    function automatic int unsigned center(input int unsigned lo, input int unsigned hi);
        return (lo + hi) / 2;
    endfunction

    // Full 32-bit unsigned compare so huge writes saturate instead of wrapping.
    function automatic logic [31:0] clamp(input logic [31:0] d, input logic [31:0] lo, input logic [31:0] hi);
        return (d < lo) ? lo : (d > hi) ? hi : d;
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel: one servo's target, slew-limited current position and registered PWM compare.
module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int CW      = 20,
    parameter int MIN_CYC = 50000,
    parameter int MAX_CYC = 100000
) (
    input  logic          clk,
    input  logic          reset_low,
    input  logic          tgt_we,
    input  logic [CW-1:0] tgt_val,
    input  logic [CW-1:0] step,
    input  logic          en,
    input  logic          frame_start,
    input  logic [CW-1:0] count,
    output logic [CW-1:0] target,
    output logic [CW-1:0] current,
    output logic          pwm
);

    localparam logic [CW-1:0] CENTER = CW'(center(MIN_CYC, MAX_CYC));

    logic [CW-1:0] target_q, target_d, current_q, current_d;
    logic          pwm_q, pwm_d, up;
    logic [CW:0]   diff;

    always_comb begin
        target_d  = tgt_we ? tgt_val : target_q;
        up        = target_q >= current_q;
        diff      = up ? {1'b0, target_q} - {1'b0, current_q} : {1'b0, current_q} - {1'b0, target_q};
        // Final step lands exactly on target, so there is no overshoot.
        current_d = !en ? target_q :
                    !frame_start ? current_q :
                    (step == '0 || diff <= {1'b0, step}) ? target_q :
                    up ? current_q + step : current_q - step;
        pwm_d     = en && (count < current_q);
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            target_q  <= CENTER;
            current_q <= CENTER;
            pwm_q     <= 1'b0;
        end else begin
            target_q  <= target_d;
            current_q <= current_d;
            pwm_q     <= pwm_d;
        end
    end

    assign target  = target_q;
    assign current = current_q;
    assign pwm     = pwm_q;

endmodule

// File: rtl/servo_multi_pos_avalon.sv
// servo_multi_pos_avalon: Avalon-MM multi-channel servo controller sharing one frame counter.
module servo_multi_pos_avalon
    import servo_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int PERIOD_CYC = 1000000,
    parameter int MIN_CYC    = 50000,
    parameter int MAX_CYC    = 100000,
    parameter int CW         = 20,
    parameter int ADDR_W     = $clog2(2 + 2 * NUM_CH)
) (
    input  logic              clock_clk,
    input  logic              reset_low,
    input  logic              cs,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

    logic          en_q, en_d;
    logic [CW-1:0] step_q, step_d, count_q, count_d, tgt_val;
    logic [31:0]   readdata_q, readdata_d, addr;
    logic          we, rd, frame_start;
    logic [CW-1:0] target [NUM_CH];
    logic [CW-1:0] current [NUM_CH];

    assign addr        = 32'(address);
    assign we          = cs && write;
    assign rd          = cs && read;
    assign tgt_val     = CW'(clamp(writedata, MIN_CYC, MAX_CYC));
    assign frame_start = en_q && count_q == '0;

    always_comb begin
        en_d       = (we && addr == ADDR_CTRL) ? writedata[CTRL_EN] : en_q;
        step_d     = (we && addr == ADDR_STEP) ? writedata[CW-1:0] : step_q;
        count_d    = (!en_q || count_q == LAST) ? '0 : count_q + 1'b1;
        readdata_d = readdata_q;
        if (rd) begin
            readdata_d = '0;
            if (addr == ADDR_CTRL) readdata_d = 32'(en_q);
            if (addr == ADDR_STEP) readdata_d = 32'(step_q);
            for (int i = 0; i < NUM_CH; i++) begin
                if (addr == ADDR_TARGET + i) readdata_d = 32'(target[i]);
                if (addr == addr_current(NUM_CH) + i) readdata_d = 32'(current[i]);
            end
        end
    end

    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) begin
            en_q       <= 1'b0;
            step_q     <= '0;
            count_q    <= '0;
            readdata_q <= '0;
        end else begin
            en_q       <= en_d;
            step_q     <= step_d;
            count_q    <= count_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            servo_pwm_channel #(
                .CW      (CW),
                .MIN_CYC (MIN_CYC),
                .MAX_CYC (MAX_CYC)
            ) u_ch (
                .clk         (clock_clk),
                .reset_low   (reset_low),
                .tgt_we      (we && addr == ADDR_TARGET + c),
                .tgt_val     (tgt_val),
                .step        (step_q),
                .en          (en_q),
                .frame_start (frame_start),
                .count       (count_q),
                .target      (target[c]),
                .current     (current[c]),
                .pwm         (pwm_out[c])
            );
        end
    endgenerate

endmodule

// File: tb/tb_servo_multi_pos_avalon.sv
// tb_servo_multi_pos_avalon: directed vectors plus frame-timed sequences for the servo controller.
module tb_servo_multi_pos_avalon;

    localparam int NUM_CH = 4;
    localparam int AW     = 4;

    typedef struct {
        logic [AW-1:0] wa;
        logic [31:0]   wd;
        logic [AW-1:0] ra;
        logic [31:0]   exp;
        string         nm;
    } vec_t;

    logic              clk = 1'b0, rst_n = 1'b0, cs = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic [31:0]       wdata = '0;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] pwm;
    int                total = 0, bad = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    servo_multi_pos_avalon #(
        .NUM_CH     (NUM_CH),
        .PERIOD_CYC (1000),
        .MIN_CYC    (50),
        .MAX_CYC    (100),
        .CW         (10),
        .ADDR_W     (AW)
    ) dut (
        .clock_clk (clk),
        .reset_low (rst_n),
        .cs        (cs),
        .write     (wr),
        .read      (rd),
        .address   (addr),
        .writedata (wdata),
        .readdata  (rdata),
        .pwm_out   (pwm)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic read_check(input string nm, input logic [AW-1:0] a, input logic [31:0] exp);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        @(negedge clk);
        check(nm, rdata, exp);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [AW-1:0] wa, input logic [31:0] wd, input logic [AW-1:0] ra,
                                input logic [31:0] exp, input string nm);
        vec_t v;
        v.wa = wa; v.wd = wd; v.ra = ra; v.exp = exp; v.nm = nm;
        return v;
    endfunction

    vec_t vecs[$];
    int   hi[NUM_CH];
    int   hf[2];
    int   up_exp[5] = '{82, 89, 96, 100, 100};
    int   dn_exp[9] = '{93, 86, 79, 72, 65, 58, 51, 50, 50};
    int   e, fs0, fs1, s, s2, r, edges;
    logic [NUM_CH-1:0] prev;

    initial begin
        // Addresses: 0 CTRL, 1 STEP, 2..5 TARGET, 6..9 CURRENT, 10..15 unmapped.
        vecs.push_back(mk(3, 32'd10,        3, 50,  "clamp_lo"));
        vecs.push_back(mk(3, 32'hFFFFFFFF,  3, 100, "clamp_hi"));
        vecs.push_back(mk(3, 32'd49,        3, 50,  "clamp_49"));
        vecs.push_back(mk(3, 32'd101,       3, 100, "clamp_101"));
        vecs.push_back(mk(3, 32'd50,        3, 50,  "clamp_min"));
        vecs.push_back(mk(3, 32'd100,       3, 100, "clamp_max"));
        vecs.push_back(mk(3, 32'd77,        3, 77,  "target_mid"));
        vecs.push_back(mk(5, 32'd90,        9, 90,  "cur_follow_dis"));
        vecs.push_back(mk(1, 32'hFFFFF407,  1, 7,   "step_mask"));
        vecs.push_back(mk(0, 32'hFFFFFFFE,  0, 0,   "ctrl_mask"));
        vecs.push_back(mk(11, 32'h12345678, 11, 0,  "unmapped_read"));
        vecs.push_back(mk(7, 32'd99,        7, 77,  "cur_readonly"));
        vecs.push_back(mk(11, 32'd55,       3, 77,  "unmapped_keep_tgt"));
        vecs.push_back(mk(11, 32'd55,       1, 7,   "unmapped_keep_step"));
        vecs.push_back(mk(11, 32'd1,        0, 0,   "unmapped_keep_ctrl"));

        repeat (3) @(negedge clk);
        check("pwm_in_reset", 32'(pwm), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdata_reset", rdata, 0);
        read_check("reset_tgt0", 2, 75);
        read_check("reset_cur3", 9, 75);
        read_check("reset_ctrl", 0, 0);
        read_check("reset_step", 1, 0);
        prev = pwm; edges = 0;
        repeat (3000) begin
            @(negedge clk);
            if (pwm !== prev) edges++;
            prev = pwm;
        end
        check("no_edges_disabled", edges, 0);

        foreach (vecs[i]) begin
            bus_write(vecs[i].wa, vecs[i].wd);
            @(negedge clk);
            read_check(vecs[i].nm, vecs[i].ra, vecs[i].exp);
        end
        bus_write(3, 75);
        bus_write(5, 75);
        bus_write(1, 0);

        // Read and write of TARGET0 in one cycle returns the old value.
        cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = 2; wdata = 60;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        @(negedge clk);
        check("rw_same_old", rdata, 75);
        read_check("rw_same_new", 2, 60);
        bus_write(0, 1);
        e = cyc;
        check("pwm_before_frame", 32'(pwm), 0);
        foreach (hi[ch]) hi[ch] = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (k == 1) check("rise_aligned", 32'(pwm), 32'hF);
            for (int ch = 0; ch < NUM_CH; ch++) if (pwm[ch]) hi[ch]++;
        end
        check("width_ch0", hi[0], 60);
        check("width_ch1", hi[1], 75);
        check("width_ch2", hi[2], 75);
        check("width_ch3", hi[3], 75);

        fs0 = e + 1001;
        bus_write(1, 7);
        bus_write(4, 100);
        for (int i = 1; i <= 5; i++) begin
            wait_to(fs0 + 1000 * i + 2);
            read_check("slew_up", 8, up_exp[i-1]);
        end
        bus_write(4, 50);
        fs1 = fs0 + 5000;
        for (int i = 1; i <= 9; i++) begin
            wait_to(fs1 + 1000 * i + 2);
            read_check("slew_down", 8, dn_exp[i-1]);
        end

        bus_write(1, 0);
        s = fs1 + 10000;
        wait_to(s - 1);
        cs = 1'b1; wr = 1'b1; addr = 2; wdata = 90;
        hf[0] = 0; hf[1] = 0;
        for (int j = 0; j < 2000; j++) begin
            @(negedge clk);
            if (j == 0) begin cs = 1'b0; wr = 1'b0; end
            if (pwm[0]) hf[j / 1000]++;
        end
        check("edge_write_old_frame", hf[0], 60);
        check("edge_write_next_frame", hf[1], 90);

        s2 = s + 2000;
        wait_to(s2 + 19);
        bus_write(0, 0);
        check("pulse_before_disable", 32'(pwm[0]), 1);
        @(negedge clk);
        check("disable_drop", 32'(pwm), 0);
        wait_to(s2 + 29);
        bus_write(0, 1);
        r = cyc;
        check("reenable_wait", 32'(pwm), 0);
        hi[0] = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (k == 1) check("reenable_rise", 32'(pwm), 32'hF);
            if (pwm[0]) hi[0]++;
        end
        check("reenable_width", hi[0], 90);

        bus_write(1, 3);
        bus_write(4, 100);
        wait_to(r + 3003);
        read_check("ramp_before_reset", 8, 56);
        wait_to(r + 3011);
        check("mid_pulse", 32'(pwm), 32'hF);
        #2 rst_n = 1'b0;
        #1;
        check("async_pwm_drop", 32'(pwm), 0);
        check("async_rdata_clr", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            read_check("post_reset_tgt", AW'(2 + ch), 75);
            read_check("post_reset_cur", AW'(6 + ch), 75);
        end
        read_check("post_reset_ctrl", 0, 0);
        read_check("post_reset_step", 1, 0);
        edges = 0;
        repeat (50) begin
            @(negedge clk);
            if (pwm !== '0) edges++;
        end
        check("post_reset_idle", edges, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
